// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: keeps up to DEPTH imem requests in flight and buffers
// returned instructions in an in-order queue; jumps flush the queue and drop stale responses.
module fetch_prefetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_enable,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc_4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic              flush_busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DepthC = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]     inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc4_mem [DEPTH];
  logic [ADDR_W-1:0] jump_target;
  logic [CW:0]       credit_used;
  logic              push, pop;
  logic              unused_jump_lsb;

  assign jump_target     = {jump_address[ADDR_W-1:2], 2'b00};
  assign unused_jump_lsb = ^jump_address[1:0];

  // Queue entries plus outstanding requests never exceed DEPTH, so pushes cannot overflow.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req    = fetch_enable && !jump_valid && (credit_used < DepthC);
  assign imem_addr   = fetch_pc_q;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = imem_rsp_valid && (drop_q == '0) && !jump_valid;
  assign inst       = inst_valid ? inst_mem[rd_ptr_q] : '0;
  assign pc_4       = inst_valid ? pc4_mem[rd_ptr_q] : '0;
  assign occupancy  = count_q;
  assign flush_busy = (drop_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q + CW'(imem_req) - CW'(imem_rsp_valid);
    if (jump_valid) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      fetch_pc_d = jump_target;
      resp_pc_d  = jump_target;
      drop_d     = inflight_q - CW'(imem_rsp_valid);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (imem_rsp_valid) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else resp_pc_d = resp_pc_q + ADDR_W'(4);
      end
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rsp_data;
      pc4_mem[wr_ptr_q]  <= resp_pc_q + ADDR_W'(4);
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CW'(DEPTH))));

endmodule
